// File: rtl/y86_regfile_2w_if.sv
// Decode/writeback bus of the two-write-port Y86-64 register file.
// master = pipeline side driving indices and write data; slave = register file.
interface y86_regfile_2w_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] srcA;
    logic [ADDR_W-1:0] srcB;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic              wr_en;
    logic [ADDR_W-1:0] dstE;
    logic [DATA_W-1:0] valE;
    logic [ADDR_W-1:0] dstM;
    logic [DATA_W-1:0] valM;
    logic [ADDR_W-1:0] dbg_sel;
    logic [DATA_W-1:0] dbg_val;
    logic [CNT_W-1:0]  wr_count;

    modport master (
        output srcA, srcB, wr_en, dstE, valE, dstM, valM, dbg_sel,
        input  valA, valB, dbg_val, wr_count
    );

    modport slave (
        input  srcA, srcB, wr_en, dstE, valE, dstM, valM, dbg_sel,
        output valA, valB, dbg_val, wr_count
    );
endinterface

// File: rtl/y86_regfile_2w.sv
// Y86-64 register file: two combinational read ports, E/M write ports, saturating write counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto valA/valB.
module y86_regfile_2w #(
    parameter int                DATA_W  = 64,
    parameter int                ADDR_W  = 4,
    parameter int                NREGS   = 15,
    parameter int                SP_IDX  = 4,
    parameter logic [DATA_W-1:0] SP_INIT = 64'h0000_0000_0000_0200,
    parameter int                CNT_W   = 16
) (
    input logic               clk,
    input logic               rst_n,
    y86_regfile_2w_if.slave   rf
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W:0]    cnt_sum;
    logic [1:0]        n_wr;
    logic              we_e;
    logic              we_m;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] rd_dbg;

    function automatic logic in_range(input logic [ADDR_W-1:0] idx);
        return int'(idx) < NREGS;
    endfunction

    // M wins a dstE == dstM collision, so E is dropped and the pair counts once
    always_comb begin
        we_m    = rf.wr_en && in_range(rf.dstM);
        we_e    = rf.wr_en && in_range(rf.dstE) && !(we_m && (rf.dstE == rf.dstM));
        n_wr    = {1'b0, we_e} + {1'b0, we_m};
        cnt_sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, n_wr};
        cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_comb begin
        rd_a   = '0;
        rd_b   = '0;
        rd_dbg = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rf.srcA == ADDR_W'(i))    rd_a   = regs_q[i];
            if (rf.srcB == ADDR_W'(i))    rd_b   = regs_q[i];
            if (rf.dbg_sel == ADDR_W'(i)) rd_dbg = regs_q[i];
        end
`ifdef REGFILE_BYPASS_EN
        // forwarding ignores rst_n: reset only blocks the array update
        if (rf.wr_en && in_range(rf.srcA)) begin
            if (rf.srcA == rf.dstM)      rd_a = rf.valM;
            else if (rf.srcA == rf.dstE) rd_a = rf.valE;
        end
        if (rf.wr_en && in_range(rf.srcB)) begin
            if (rf.srcB == rf.dstM)      rd_b = rf.valM;
            else if (rf.srcB == rf.dstE) rd_b = rf.valE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we_m && (rf.dstM == ADDR_W'(i)))      regs_q[i] <= rf.valM;
                else if (we_e && (rf.dstE == ADDR_W'(i))) regs_q[i] <= rf.valE;
            end
            cnt_q <= cnt_d;
        end
    end

    assign rf.valA     = rd_a;
    assign rf.valB     = rd_b;
    assign rf.dbg_val  = rd_dbg;
    assign rf.wr_count = cnt_q;

endmodule

// File: tb/tb_y86_regfile_2w.sv
// Scoreboard bench: three register-file builds (default, NREGS=8, CNT_W=2) share one stimulus stream.
module tb_y86_regfile_2w;

    localparam bit BYP =
`ifdef REGFILE_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    y86_regfile_2w_if #(.DATA_W(64), .ADDR_W(4), .CNT_W(16)) if0 ();
    y86_regfile_2w_if #(.DATA_W(64), .ADDR_W(4), .CNT_W(16)) if1 ();
    y86_regfile_2w_if #(.DATA_W(64), .ADDR_W(4), .CNT_W(2))  if2 ();

    y86_regfile_2w u0 (.clk(clk), .rst_n(rst_n), .rf(if0));
    y86_regfile_2w #(.NREGS(8)) u1 (.clk(clk), .rst_n(rst_n), .rf(if1));
    y86_regfile_2w #(.CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .rf(if2));

    logic [63:0] obs [3][4];
    assign obs[0][0] = if0.valA;
    assign obs[0][1] = if0.valB;
    assign obs[0][2] = if0.dbg_val;
    assign obs[0][3] = 64'(if0.wr_count);
    assign obs[1][0] = if1.valA;
    assign obs[1][1] = if1.valB;
    assign obs[1][2] = if1.dbg_val;
    assign obs[1][3] = 64'(if1.wr_count);
    assign obs[2][0] = if2.valA;
    assign obs[2][1] = if2.valB;
    assign obs[2][2] = if2.dbg_val;
    assign obs[2][3] = 64'(if2.wr_count);

    typedef struct {
        int          dut;
        int          sig;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t chk_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: architectural contents and a plain integer write tally
    logic [63:0] mdl [3][16];
    int          cnt [3];
    int          nr [3]   = '{15, 8, 15};
    int          cmax [3] = '{65535, 65535, 3};
    bit          mvalid   = 1'b0;
    string       sig_name [4] = '{"valA", "valB", "dbg_val", "wr_count"};

    function automatic logic [63:0] m_rd(input int d, input logic [3:0] idx);
        if (int'(idx) < nr[d]) return mdl[d][idx];
        return 64'h0;
    endfunction

    function automatic logic [63:0] m_port(input int d, input logic [3:0] s, input logic we,
                                           input logic [3:0] de, input logic [63:0] ve,
                                           input logic [3:0] dm, input logic [63:0] vm);
        if (BYP && we && int'(s) < nr[d]) begin
            if (s == dm) return vm;
            if (s == de) return ve;
        end
        return m_rd(d, s);
    endfunction

    task automatic m_commit(input logic rst, input logic we, input logic [3:0] de,
                            input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                for (int i = 0; i < 16; i++) mdl[d][i] = 64'h0;
                mdl[d][4] = 64'h200;
                cnt[d] = 0;
            end else if (we) begin
                int n = 0;
                bit e_ok = int'(de) < nr[d];
                bit m_ok = int'(dm) < nr[d];
                if (e_ok) begin mdl[d][de] = ve; n++; end
                if (m_ok) begin mdl[d][dm] = vm; n++; end
                if (e_ok && m_ok && de == dm) n--;
                cnt[d] = (cnt[d] + n > cmax[d]) ? cmax[d] : cnt[d] + n;
            end
        end
    endtask

    task automatic push(input int d, input int s, input logic [63:0] e, input string tag);
        chk_t c;
        c.dut  = d;
        c.sig  = s;
        c.exp  = e;
        c.name = $sformatf("%s.u%0d.%s", tag, d, sig_name[s]);
        chk_q.push_back(c);
    endtask

    task automatic check_now(input int d, input int s, input logic [63:0] e, input string tag);
        logic [63:0] act;
        act = obs[d][s];
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s.u%0d.%s: got %h, expected %h", tag, d, sig_name[s], act, e);
        end
    endtask

    task automatic cyc(input logic rst, input logic we, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm, input logic [3:0] sa,
                       input logic [3:0] sb, input logic [3:0] ds, input string tag);
        rst_n = rst;
        if0.wr_en = we; if0.dstE = de; if0.valE = ve; if0.dstM = dm; if0.valM = vm;
        if0.srcA = sa;  if0.srcB = sb; if0.dbg_sel = ds;
        if1.wr_en = we; if1.dstE = de; if1.valE = ve; if1.dstM = dm; if1.valM = vm;
        if1.srcA = sa;  if1.srcB = sb; if1.dbg_sel = ds;
        if2.wr_en = we; if2.dstE = de; if2.valE = ve; if2.dstM = dm; if2.valM = vm;
        if2.srcA = sa;  if2.srcB = sb; if2.dbg_sel = ds;
        if (mvalid) begin
            for (int d = 0; d < 3; d++) begin
                push(d, 0, m_port(d, sa, we, de, ve, dm, vm), tag);
                push(d, 1, m_port(d, sb, we, de, ve, dm, vm), tag);
                push(d, 2, m_rd(d, ds), tag);
                push(d, 3, 64'(cnt[d]), tag);
            end
        end
        @(posedge clk);
        m_commit(rst, we, de, ve, dm, vm);
        mvalid = 1'b1;
        #1;
    endtask

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : monitor
        chk_t        c;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c   = chk_q.pop_front();
                act = obs[c.dut][c.sig];
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    initial begin : stim
        logic [3:0]  de, dm, sa, sb, ds;
        logic [63:0] ve, vm;
        logic        we, rst;
        cyc(1'b0, 1'b1, 4'd5, 64'h99, 4'd5, 64'h98, 4'd4, 4'd0, 4'd4, "rst");
        check_now(0, 0, 64'h200, "rst_state");
        check_now(0, 1, 64'h0, "rst_state");
        check_now(0, 3, 64'h0, "rst_state");
        cyc(1'b1, 1'b0, 4'd0, 64'h0, 4'd0, 64'h0, 4'd4, 4'd0, 4'd4, "rst_rd");
        cyc(1'b1, 1'b0, 4'd0, 64'h0, 4'd0, 64'h0, 4'd15, 4'd5, 4'd15, "rnone_rd");
        cyc(1'b1, 1'b1, 4'd3, 64'hAA, 4'd7, 64'hBB, 4'd3, 4'd7, 4'd3, "dual_wr");
        cyc(1'b1, 1'b0, 4'd0, 64'h0, 4'd0, 64'h0, 4'd3, 4'd7, 4'd7, "dual_rd");
        cyc(1'b1, 1'b1, 4'd4, 64'h1F8, 4'd4, 64'h55, 4'd4, 4'd3, 4'd4, "conflict");
        cyc(1'b1, 1'b0, 4'd1, 64'h9, 4'd15, 64'h0, 4'd4, 4'd1, 4'd1, "gated");
        cyc(1'b1, 1'b0, 4'd0, 64'h0, 4'd0, 64'h0, 4'd1, 4'd4, 4'd1, "gated_rd");
        cyc(1'b1, 1'b1, 4'd15, 64'hFF, 4'd15, 64'h0, 4'd15, 4'd14, 4'd15, "rnone_wr");
        cyc(1'b1, 1'b1, 4'd9, 64'h123, 4'd15, 64'h0, 4'd9, 4'd1, 4'd9, "oor_wr");
        cyc(1'b1, 1'b0, 4'd0, 64'h0, 4'd0, 64'h0, 4'd9, 4'd1, 4'd9, "oor_rd");
        cyc(1'b1, 1'b1, 4'd2, 64'h77, 4'd15, 64'h0, 4'd2, 4'd2, 4'd2, "bypass");
        cyc(1'b1, 1'b0, 4'd0, 64'h0, 4'd0, 64'h0, 4'd2, 4'd3, 4'd2, "bypass_after");
        cyc(1'b0, 1'b0, 4'd0, 64'h0, 4'd0, 64'h0, 4'd0, 4'd0, 4'd0, "sat_rst");
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 4'(k), 64'(k + 16), 4'(k + 8), 64'(k + 32), 4'(k), 4'(k + 8), 4'd0, "sat");
        end
        cyc(1'b1, 1'b0, 4'd0, 64'h0, 4'd0, 64'h0, 4'd8, 4'd3, 4'd9, "sat_rd");
        cyc(1'b1, 1'b1, 4'd5, 64'hABC, 4'd15, 64'h0, 4'd5, 4'd0, 4'd5, "pre_rst");
        cyc(1'b0, 1'b1, 4'd5, 64'hDEAD, 4'd6, 64'hBEEF, 4'd5, 4'd6, 4'd5, "mid_rst");
        check_now(0, 2, 64'h0, "mid_rst_state");
        check_now(0, 3, 64'h0, "mid_rst_state");
        check_now(2, 3, 64'h0, "mid_rst_state");
        cyc(1'b1, 1'b0, 4'd0, 64'h0, 4'd0, 64'h0, 4'd5, 4'd6, 4'd5, "mid_rst_rd");

        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 39) != 0);
            we  = ($urandom_range(0, 3) != 0);
            de  = 4'($urandom_range(0, 15));
            dm  = ($urandom_range(0, 4) == 0) ? de : 4'($urandom_range(0, 15));
            ve  = {$urandom, $urandom};
            vm  = {$urandom, $urandom};
            sa  = ($urandom_range(0, 2) == 0) ? de : 4'($urandom_range(0, 15));
            sb  = ($urandom_range(0, 2) == 0) ? dm : 4'($urandom_range(0, 15));
            ds  = ($urandom_range(0, 2) == 0) ? de : 4'($urandom_range(0, 15));
            cyc(rst, we, de, ve, dm, vm, sa, sb, ds, "rand");
        end
        cyc(1'b1, 1'b0, 4'd0, 64'h0, 4'd0, 64'h0, 4'd4, 4'd7, 4'd2, "final");
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
